// File: rtl/aes256_key_expand_seq.sv
// AES-256 forward key schedule: one 256-bit expansion step per cycle,
// all 15 round keys held in a register file and read back by index.
module aes256_key_expand_seq #(
  parameter int NRK  = 15,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [0:255]    key_in,
  input  logic            key_valid,
  output logic            key_ready,
  output logic            busy,
  output logic            keys_valid,
  input  logic            rk_rd,
  input  logic [IDXW-1:0] rk_idx,
  output logic [0:127]    rk_out,
  output logic            rk_out_valid,
  output logic            rk_err
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{a, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [0:255] w_q;
  logic [2:0]   step_q;
  logic [0:127] rk [NRK];

  logic        accept;
  logic        last_step;
  logic        rd_ok;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w4, w5, w6, w7;
  logic [31:0] rot7;
  logic [31:0] sub_rot;
  logic [31:0] sub_n3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] n4, n5, n6, n7;

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == READY);
  assign accept     = key_valid & key_ready;
  assign last_step  = (step_q == 3'd7);
  assign rd_ok      = keys_valid &&
                      (rk_idx <= IDXW'(NRK - 1));

  assign w0 = w_q[0   +: 32];
  assign w1 = w_q[32  +: 32];
  assign w2 = w_q[64  +: 32];
  assign w3 = w_q[96  +: 32];
  assign w4 = w_q[128 +: 32];
  assign w5 = w_q[160 +: 32];
  assign w6 = w_q[192 +: 32];
  assign w7 = w_q[224 +: 32];

  assign rcon = 8'h01 << (step_q - 3'd1);
  assign rot7 = {w7[23:0], w7[31:24]};

  // Four S-boxes on RotWord(w7), four on n3: eight per step.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_rot[31-8*g -: 8] = sbox(rot7[31-8*g -: 8]);
    assign sub_n3[31-8*g -: 8]  = sbox(n3[31-8*g -: 8]);
  end

  assign n0 = w0 ^ sub_rot ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign n4 = w4 ^ sub_n3;
  assign n5 = w5 ^ n4;
  assign n6 = w6 ^ n5;
  assign n7 = w7 ^ n6;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = EXPAND;
      EXPAND:  if (last_step) state_d = READY;
      READY:   if (accept)    state_d = EXPAND;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q          <= '0;
      step_q       <= '0;
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
      rk_err       <= 1'b0;
      for (int i = 0; i < NRK; i++) rk[i] <= '0;
    end else begin
      if (accept) begin
        rk[0]  <= key_in[0:127];
        rk[1]  <= key_in[128:255];
        w_q    <= key_in;
        step_q <= 3'd1;
      end else if (state_q == EXPAND) begin
        rk[{step_q, 1'b0}] <= {n0, n1, n2, n3};
        // Step 7 only produces RK14; slot 15 does not exist.
        if (!last_step)
          rk[{step_q, 1'b1}] <= {n4, n5, n6, n7};
        w_q    <= {n0, n1, n2, n3, n4, n5, n6, n7};
        step_q <= step_q + 3'd1;
      end
      rk_out_valid <= rk_rd;
      if (rk_rd) begin
        rk_out <= rd_ok ? rk[rk_idx] : '0;
        rk_err <= !rd_ok;
      end
    end
  end

endmodule

// File: tb/tb_aes256_key_expand_seq.sv
// Directed bench for aes256_key_expand_seq; expectations come from FIPS-197
// vectors and an independent word-wise key schedule with a GF-derived S-box.
module tb_aes256_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:255] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         rk_rd;
  logic [3:0]   rk_idx;
  logic [0:127] rk_out;
  logic         rk_out_valid;
  logic         rk_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;

  logic [7:0]   sb_t [256];
  logic [127:0] ref_rk [2][15];

  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes256_key_expand_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .busy         (busy),
    .keys_valid   (keys_valid),
    .rk_rd        (rk_rd),
    .rk_idx       (rk_idx),
    .rk_out       (rk_out),
    .rk_out_valid (rk_out_valid),
    .rk_err       (rk_err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
                rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]};
  endfunction

  task automatic expand_key(input int sel, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      ref_rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the accept edge.
  task automatic accept_key(input logic [255:0] k, input bit hold,
                            input logic [255:0] other);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    if (hold) key_in = other;
    else      key_valid = 1'b0;
    chk("acc_busy", 128'(busy), 128'd1);
    chk("acc_kv", 128'(keys_valid), 128'd0);
  endtask

  // Counts edges after the accept edge until keys_valid rises.
  task automatic wait_keys(output int c);
    c = 0;
    while (!keys_valid && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 3) begin
        chk("exp_ready", 128'(key_ready), 128'd0);
        chk("exp_busy", 128'(busy), 128'd1);
      end
      if (c >= 6) key_valid = 1'b0;
    end
  endtask

  task automatic read_chk(input string tag, input logic [3:0] idx,
                          input logic [127:0] exp, input logic err);
    @(negedge clk);
    rk_rd  = 1'b1;
    rk_idx = idx;
    @(negedge clk);
    rk_rd = 1'b0;
    chk({tag, "_v"}, 128'(rk_out_valid), 128'd1);
    chk({tag, "_e"}, 128'(rk_err), 128'(err));
    chk(tag, rk_out, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rk_rd     = 1'b0;
    rk_idx    = '0;
    build_sbox();
    expand_key(0, KEY_A3);
    expand_key(1, KEY_C3);

    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kv", 128'(keys_valid), 128'd0);
    chk("rst_out", rk_out, 128'd0);
    chk("rst_ov", 128'(rk_out_valid), 128'd0);
    chk("rst_err", 128'(rk_err), 128'd0);
    rst_n = 1'b1;

    read_chk("rd_nokey", 4'd0, 128'd0, 1'b1);

    // C.3 key, with a different key held on the input during expansion
    accept_key(KEY_C3, 1'b1, KEY_A3);
    wait_keys(cnt);
    chk("c3_lat", 128'(cnt), 128'd7);
    read_chk("c3_rk0", 4'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    read_chk("c3_rk1", 4'd1, 128'h101112131415161718191a1b1c1d1e1f, 1'b0);
    read_chk("c3_rk2", 4'd2, 128'ha573c29fa176c498a97fce93a572c09c, 1'b0);
    read_chk("c3_rk14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0);
    read_chk("c3_rk7m", 4'd7, ref_rk[1][7], 1'b0);
    read_chk("rd_idx15", 4'd15, 128'd0, 1'b1);
    @(negedge clk);
    chk("ov_drop", 128'(rk_out_valid), 128'd0);
    chk("err_hold", 128'(rk_err), 128'd1);

    // Reload A.3 with a same-cycle read of the old RK1
    @(negedge clk);
    key_in    = KEY_A3;
    key_valid = 1'b1;
    rk_rd     = 1'b1;
    rk_idx    = 4'd1;
    @(negedge clk);
    key_valid = 1'b0;
    rk_rd     = 1'b0;
    chk("same_rk1", rk_out, 128'h101112131415161718191a1b1c1d1e1f);
    chk("same_err", 128'(rk_err), 128'd0);
    chk("same_kv", 128'(keys_valid), 128'd0);
    wait_keys(cnt);
    chk("a3_lat", 128'(cnt), 128'd7);
    read_chk("a3_rk2", 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde, 1'b0);

    // Back-to-back reverse reads
    @(negedge clk);
    rk_rd  = 1'b1;
    rk_idx = 4'd14;
    for (int i = 14; i >= 0; i--) begin
      @(negedge clk);
      if (i > 0) rk_idx = 4'(i - 1);
      else       rk_rd = 1'b0;
      chk("rev_v", 128'(rk_out_valid), 128'd1);
      chk("rev_e", 128'(rk_err), 128'd0);
      chk("rev", rk_out, ref_rk[0][i]);
    end
    @(negedge clk);
    chk("rev_end_v", 128'(rk_out_valid), 128'd0);
    chk("rev_hold", rk_out, ref_rk[0][0]);

    // Reset while step 4 is due
    accept_key(KEY_C3, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_ready", 128'(key_ready), 128'd1);
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_kv", 128'(keys_valid), 128'd0);
    chk("mid_out", rk_out, 128'd0);
    chk("mid_ov", 128'(rk_out_valid), 128'd0);
    chk("mid_err", 128'(rk_err), 128'd0);
    repeat (8) @(negedge clk);
    chk("mid_kv_late", 128'(keys_valid), 128'd0);
    read_chk("mid_rd", 4'd0, 128'd0, 1'b1);

    accept_key(KEY_A3, 1'b0, '0);
    wait_keys(cnt);
    chk("post_lat", 128'(cnt), 128'd7);
    read_chk("post_rk14", 4'd14, ref_rk[0][14], 1'b0);
    read_chk("post_rk9", 4'd9, ref_rk[0][9], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
